// File: rtl/wb_cmd_master_if.sv
// Command/response stream plus Wishbone classic bus bundle for wb_cmd_master.
// Member suffixes are from the initiator's point of view.
interface wb_cmd_master_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned SW = DW / 8;

  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_we_i;
  logic [AW-1:0] cmd_adr_i;
  logic [DW-1:0] cmd_dat_i;
  logic [SW-1:0] cmd_sel_i;

  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_dat_o;
  logic          rsp_err_o;

  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic          wbm_we_o;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o;
  logic [SW-1:0] wbm_sel_o;
  logic [DW-1:0] wbm_dat_i;
  logic          wbm_ack_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  rsp_ready_i,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_err_o,
    output rsp_ready_i,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one valid/ready command becomes one single
// read/write bus cycle, with the outcome returned on a valid/ready response.
module wb_cmd_master #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  wb_cmd_master_if.master    bus,
  output logic               busy_o
);
  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_dat_q, rsp_dat_d;
  logic          rsp_err_q, rsp_err_d;
  logic          busy_q, busy_d;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid_i) begin
          state_d = BUS;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = bus.cmd_we_i;
          adr_d   = bus.cmd_adr_i;
          dat_d   = bus.cmd_dat_i;
          sel_d   = bus.cmd_sel_i;
        end
      end
      BUS: begin
        // Ack takes priority over a coinciding timeout.
        if (bus.wbm_ack_i || (cnt_q == CNT_LAST)) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          adr_d       = '0;
          dat_d       = '0;
          sel_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = !bus.wbm_ack_i;
          rsp_dat_d   = (bus.wbm_ack_i && !we_q) ? bus.wbm_dat_i : '0;
        end
        if (!bus.wbm_ack_i) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b0;
          cnt_d       = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign bus.cmd_ready_o = (state_q == IDLE);
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_dat_o   = rsp_dat_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.wbm_cyc_o   = cyc_q;
  assign bus.wbm_stb_o   = stb_q;
  assign bus.wbm_we_o    = we_q;
  assign bus.wbm_adr_o   = adr_q;
  assign bus.wbm_dat_o   = dat_q;
  assign bus.wbm_sel_o   = sel_q;
  assign busy_o          = busy_q;
endmodule
